// File: rtl/aes_pkg.sv
// Shared AES constants and helpers.
//   Sbox      : forward S-box, 256 x 8
//   rcon_of   : round constant for index 1..10 (0 elsewhere)
//   nr_of     : number of rounds for a key length in words
//   RkWidth   : round-key width in bits
//   key_state_e : key-schedule FSM states
package aes_pkg;

  localparam int unsigned RkWidth = 128;

  localparam logic [7:0] Sbox [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {StIdle, StGen, StDrain} key_state_e;

  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int unsigned nr_of(input int unsigned nk);
    return nk + 6;
  endfunction

endpackage

// File: rtl/key_schedule_if.sv
// Key-schedule control and round-key handshake bundle.
//   start, key_in      : request a new expansion (key bit 0 = MSB of byte 0)
//   busy, done         : expansion status, done pulses once per expansion
//   rk, rk_index       : round key and its round number
//   rk_valid, rk_ready : round-key valid/ready handshake
// master = key schedule, slave = consumer/controller.
interface key_schedule_if
  import aes_pkg::*;
#(
  parameter int unsigned Nk = 4
);
  logic                  start;
  logic [0:32*Nk-1]      key_in;
  logic                  busy;
  logic [0:RkWidth-1]    rk;
  logic                  rk_valid;
  logic                  rk_ready;
  logic [3:0]            rk_index;
  logic                  done;

  modport master (
    input  start, key_in, rk_ready,
    output busy, rk, rk_valid, rk_index, done
  );

  modport slave (
    output start, key_in, rk_ready,
    input  busy, rk, rk_valid, rk_index, done
  );
endinterface

// File: rtl/key_sub_word.sv
// SubWord: S-box substitution on each byte of a 32-bit word.
//   word : input word
//   sub  : substituted word
module key_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);
  always_comb begin
    sub = '0;
    for (int b = 0; b < 4; b++) begin
      sub[8*b +: 8] = Sbox[word[8*b +: 8]];
    end
  end
endmodule

// File: rtl/key_schedule.sv
// Iterative AES key expansion, one schedule word per cycle, round keys handed
// out in order over a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : key_schedule_if master (start/key_in in, busy/done/rk* out)
module key_schedule
  import aes_pkg::*;
#(
  parameter int unsigned Nk = 4
) (
  input logic            clk,
  input logic            rst_n,
  key_schedule_if.master bus
);
  localparam int unsigned Nr       = nr_of(Nk);
  localparam int unsigned NumWords = 4 * (Nr + 1);
  localparam logic [5:0]  LastWord = 6'(NumWords - 1);
  localparam logic [2:0]  LastMod  = 3'(Nk - 1);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("key_schedule: Nk must be 4, 6 or 8");
  end

  key_state_e         state_q;
  logic [5:0]         cnt_q;    // schedule word index i
  logic [2:0]         mod_q;    // i mod Nk
  logic [3:0]         rnd_q;    // i / Nk, the Rcon index
  logic [31:0]        win_q [Nk];
  logic [31:0]        col_q [3];
  logic [0:RkWidth-1] rk_q;
  logic               rk_valid_q;
  logic [3:0]         rk_index_q;
  logic               busy_q;
  logic               done_q;

  logic [31:0] prev, sub_in, sub_out, temp, new_word;
  logic        stall, push;

  key_sub_word u_sub_word (
    .word (sub_in),
    .sub  (sub_out)
  );

  // The window shifts on every push, including the first Nk: after Nk pushes
  // it has rotated back to the key itself, so win_q[0] is always w[i-Nk]
  // (or key word i while i < Nk) and win_q[Nk-1] is w[i-1].
  always_comb begin
    prev   = win_q[Nk-1];
    sub_in = (mod_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    if (mod_q == 3'd0) begin
      temp = sub_out ^ {rcon_of(rnd_q), 24'h0};
    end else if (Nk == 8 && mod_q == 3'd4) begin
      temp = sub_out;
    end else begin
      temp = prev;
    end
    new_word = (cnt_q < 6'(Nk)) ? win_q[0] : (win_q[0] ^ temp);
    stall    = (cnt_q[1:0] == 2'd3) && rk_valid_q && !bus.rk_ready;
    push     = (state_q == StGen) && !stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mod_q      <= '0;
      rnd_q      <= '0;
      for (int k = 0; k < Nk; k++) win_q[k] <= '0;
      for (int k = 0; k < 3; k++) col_q[k] <= '0;
      rk_q       <= '0;
      rk_valid_q <= 1'b0;
      rk_index_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (rk_valid_q && bus.rk_ready) rk_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            for (int k = 0; k < Nk; k++) win_q[k] <= bus.key_in[32*k +: 32];
            for (int k = 0; k < 3; k++) col_q[k] <= '0;
            cnt_q   <= '0;
            mod_q   <= '0;
            rnd_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StGen;
          end
        end
        StGen: begin
          if (push) begin
            for (int k = 0; k < Nk - 1; k++) win_q[k] <= win_q[k+1];
            win_q[Nk-1] <= new_word;
            if (cnt_q[1:0] == 2'd3) begin
              rk_q       <= {col_q[0], col_q[1], col_q[2], new_word};
              rk_valid_q <= 1'b1;
              rk_index_q <= cnt_q[5:2];
              for (int k = 0; k < 3; k++) col_q[k] <= '0;
            end else begin
              col_q[cnt_q[1:0]] <= new_word;
            end
            cnt_q <= cnt_q + 6'd1;
            if (mod_q == LastMod) begin
              mod_q <= '0;
              rnd_q <= rnd_q + 4'd1;
            end else begin
              mod_q <= mod_q + 3'd1;
            end
            if (cnt_q == LastWord) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (rk_valid_q && bus.rk_ready) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rk       = rk_q;
  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_index = rk_index_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_key_schedule.sv
module tb_key_schedule;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start;
  logic         ready;
  logic [0:255] key_v;
  int           sel;

  int vectors = 0;
  int errors  = 0;

  key_schedule_if #(.Nk(4)) if4 ();
  key_schedule_if #(.Nk(6)) if6 ();
  key_schedule_if #(.Nk(8)) if8 ();

  key_schedule #(.Nk(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  key_schedule #(.Nk(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(if6));
  key_schedule #(.Nk(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  assign if4.start    = start && (sel == 4);
  assign if6.start    = start && (sel == 6);
  assign if8.start    = start && (sel == 8);
  assign if4.rk_ready = (sel == 4) ? ready : 1'b1;
  assign if6.rk_ready = (sel == 6) ? ready : 1'b1;
  assign if8.rk_ready = (sel == 8) ? ready : 1'b1;
  assign if4.key_in   = key_v[0:127];
  assign if6.key_in   = key_v[0:191];
  assign if8.key_in   = key_v;

  logic [0:127] m_rk;
  logic [3:0]   m_idx;
  logic         m_valid, m_busy, m_done;

  always_comb begin
    case (sel)
      6: begin
        m_rk = if6.rk; m_idx = if6.rk_index; m_valid = if6.rk_valid;
        m_busy = if6.busy; m_done = if6.done;
      end
      8: begin
        m_rk = if8.rk; m_idx = if8.rk_index; m_valid = if8.rk_valid;
        m_busy = if8.busy; m_done = if8.done;
      end
      default: begin
        m_rk = if4.rk; m_idx = if4.rk_index; m_valid = if4.rk_valid;
        m_busy = if4.busy; m_done = if4.done;
      end
    endcase
  end

  // Reference model: S-box from GF(2^8) inversion plus affine map, and key
  // expansion written straight from the FIPS-197 recurrence.
  logic [7:0]   sbox_m [256];
  logic [0:127] exp_rk [15];
  logic [0:127] got    [16];
  int           got_n;
  int           first_c [16];
  int           done_c;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox_m[v[31:24]], sbox_m[v[23:16]], sbox_m[v[15:8]], sbox_m[v[7:0]]};
  endfunction

  task automatic model_expand(input int nk, input logic [0:255] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic rand_key();
    for (int k = 0; k < 8; k++) key_v[32*k +: 32] = $urandom();
  endtask

  // Runs one expansion; called at a negedge, returns at the negedge showing done.
  // mode 0: rk_ready held high; mode 1: random rk_ready with a 7-cycle stall at index 1.
  task automatic run_exp(input int nk, input int mode, input bit noise, input string tag);
    int           c, hold, nr;
    bit           pend, fin;
    logic [0:127] p_rk;
    logic [3:0]   p_idx;
    nr = nk + 6; sel = nk; got_n = 0; done_c = -1;
    for (int k = 0; k < 16; k++) first_c[k] = -1;
    start = 1'b1; ready = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    c = 0; hold = 0; pend = 1'b0; fin = 1'b0;
    vectors++;
    if (m_busy !== 1'b1 || m_done !== 1'b0) begin
      errors++;
      $display("FAIL %s start_status: busy=%b done=%b required busy=1 done=0", tag, m_busy, m_done);
    end
    while (!fin && c < 3000) begin
      if (pend) begin
        vectors++;
        if (m_valid !== 1'b1 || m_rk !== p_rk || m_idx !== p_idx) begin
          errors++;
          $display("FAIL %s stall_hold: valid=%b idx=%0d rk=%h required 1 %0d %h",
                   tag, m_valid, m_idx, m_rk, p_idx, p_rk);
        end
      end
      if (m_done === 1'b1) begin
        fin = 1'b1; done_c = c;
        vectors++;
        if (got_n != nr + 1 || m_busy !== 1'b0 || m_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s done_state: keys=%0d busy=%b valid=%b required %0d 0 0",
                   tag, got_n, m_busy, m_valid, nr + 1);
        end
      end else begin
        vectors++;
        if (m_busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_level: got %b required 1 at cycle %0d", tag, m_busy, c);
        end
        if (m_valid === 1'b1 && first_c[m_idx] < 0) first_c[m_idx] = c;
        if (mode == 0) ready = 1'b1;
        else if (m_valid === 1'b1 && m_idx == 4'd1 && hold < 7) begin
          ready = 1'b0; hold++;
        end else if (m_valid === 1'b1 && m_idx == 4'd1) ready = 1'b1;
        else ready = 1'($urandom_range(0, 1));
        if (noise) start = ($urandom_range(0, 3) == 0);
        if (m_valid === 1'b1 && ready) begin
          vectors++;
          if (got_n > nr || m_idx !== 4'(got_n) || m_rk !== exp_rk[got_n]) begin
            errors++;
            $display("FAIL %s key_accept: idx=%0d rk=%h required idx=%0d rk=%h",
                     tag, m_idx, m_rk, got_n, (got_n <= nr) ? exp_rk[got_n] : 128'h0);
          end
          if (got_n < 16) got[got_n] = m_rk;
          got_n++;
          pend = 1'b0;
        end else begin
          pend = (m_valid === 1'b1); p_rk = m_rk; p_idx = m_idx;
        end
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0; ready = 1'b1;
    if (!fin) begin
      vectors++; errors++;
      $display("FAIL %s timeout: no done after %0d cycles, keys=%0d", tag, c, got_n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ready = 1'b1; sel = 4; key_v = '0;
    #2;
    vectors++;
    if ({if4.busy, if4.rk_valid, if4.done, if6.busy, if6.rk_valid, if6.done,
         if8.busy, if8.rk_valid, if8.done} !== 9'b0 ||
        if4.rk !== 128'h0 || if4.rk_index !== 4'h0 || if8.rk !== 128'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy4=%b valid4=%b rk4=%h required all zero",
               if4.busy, if4.rk_valid, if4.rk);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_aes128();
    key_v = '0;
    key_v[0:127] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_expand(4, key_v);
    run_exp(4, 0, 1'b0, "aes128");
    vectors++;
    if (got[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c ||
        got[1] !== 128'ha0fafe1788542cb123a339392a6c7605 ||
        got[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++;
      $display("FAIL aes128_kat: rk0=%h rk1=%h rk10=%h", got[0], got[1], got[10]);
    end
    for (int k = 0; k <= 10; k++) begin
      vectors++;
      if (first_c[k] != 4 + 4 * k) begin
        errors++;
        $display("FAIL aes128_latency: key %0d valid at cycle %0d required %0d",
                 k, first_c[k], 4 + 4 * k);
      end
    end
    vectors++;
    if (done_c != 45) begin
      errors++;
      $display("FAIL aes128_done_time: got cycle %0d required 45", done_c);
    end
  endtask

  task automatic test_aes192();
    key_v = '0;
    key_v[0:191] = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    model_expand(6, key_v);
    run_exp(6, 0, 1'b0, "aes192");
    vectors++;
    if (got[1] !== 128'h62f8ead2522c6b7bfe0c91f72402f5a5 || got_n != 13) begin
      errors++;
      $display("FAIL aes192_kat: rk1=%h keys=%0d required 62f8ead2522c6b7bfe0c91f72402f5a5 13",
               got[1], got_n);
    end
  endtask

  task automatic test_aes256();
    key_v = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    model_expand(8, key_v);
    run_exp(8, 0, 1'b0, "aes256");
    vectors++;
    if (got[1] !== 128'h1f352c073b6108d72d9810a30914dff4 ||
        got[2] !== 128'h9ba354118e6925afa51a8b5f2067fcde || got_n != 15) begin
      errors++;
      $display("FAIL aes256_kat: rk1=%h rk2=%h keys=%0d", got[1], got[2], got_n);
    end
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < 2; r++) begin
      rand_key();
      model_expand(4, key_v);
      run_exp(4, 1, 1'b0, "bp128");
    end
    rand_key();
    model_expand(8, key_v);
    run_exp(8, 1, 1'b0, "bp256");
  endtask

  task automatic test_start_while_busy();
    rand_key();
    model_expand(6, key_v);
    run_exp(6, 1, 1'b1, "start_noise192");
    rand_key();
    model_expand(4, key_v);
    run_exp(4, 0, 1'b1, "start_noise128");
  endtask

  task automatic test_back_to_back();
    rand_key();
    model_expand(8, key_v);
    run_exp(8, 1, 1'b0, "b2b_first");
    rand_key();
    model_expand(8, key_v);
    run_exp(8, 0, 1'b0, "b2b_second");
    vectors++;
    if (first_c[0] != 4) begin
      errors++;
      $display("FAIL b2b_restart: rk0 valid at cycle %0d required 4", first_c[0]);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    rand_key();
    model_expand(4, key_v);
    sel = 4; ready = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!(m_valid === 1'b1 && m_idx == 4'd5) && c < 200) begin
      @(negedge clk);
      c++;
    end
    vectors++;
    if (c >= 200) begin
      errors++;
      $display("FAIL reset_mid_reach: index 5 not seen, last idx=%0d", m_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (m_valid !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_rk !== 128'h0) begin
      errors++;
      $display("FAIL reset_mid_async: valid=%b busy=%b done=%b rk=%h required zeros",
               m_valid, m_busy, m_done, m_rk);
    end
    @(negedge clk); @(negedge clk);
    vectors++;
    if (m_valid !== 1'b0 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold: valid=%b busy=%b required 0 0", m_valid, m_busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_exp(4, 0, 1'b0, "reset_mid_rerun");
    vectors++;
    if (first_c[0] != 4 || first_c[10] != 44) begin
      errors++;
      $display("FAIL reset_mid_timing: rk0 at %0d rk10 at %0d required 4 44",
               first_c[0], first_c[10]);
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_backpressure();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/key_schedule.md
Name: key_schedule

Overview:
- Iterative AES key expansion (FIPS-197 §5.2); generates one 32-bit schedule word per cycle.
- Delivers 128-bit round keys in order (index 0..Nr) to the round datapath through a valid/ready handshake.
- Sits directly upstream of the round stage and drives its key input.
- Supports AES-128/192/256 through Nk.

Parameters:
- Nk, 4, key length in 32-bit words. Legal values are 4, 6 and 8 only; any other value is an elaboration error.
- Nr, Nk+6, number of rounds. Derived only; must not be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin expansion of key_in; sampled only when idle
- key_in  in  [0:32*Nk-1]  cipher key; bit 0 is the MSB of byte 0; captured on the start edge
- busy  out  1  expansion in progress
- rk  out  [0:127]  current round key, same bit ordering as key_in
- rk_valid  out  1  rk and rk_index are valid
- rk_ready  in  1  consumer accepts rk this cycle
- rk_index  out  4  round number of rk, 0..Nr
- done  out  1  one-cycle pulse after the final round key is accepted

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, word counter 0, window and collector cleared. Reset mid-expansion aborts with no further output.
- States: IDLE, GEN, DRAIN.
- IDLE:
  - start=1 latches key_in into the Nk-word window (w[0] oldest), clears word counter i, sets busy=1, moves to GEN.
  - start is ignored in all other states.
- GEN, one word pushed per cycle unless stalled:
  - i<Nk: word = key word i.
  - i≥Nk: word = w[i-Nk] ^ temp, where temp = w[i-1] transformed as follows:
    - i mod Nk = 0: SubWord(RotWord(w[i-1])) ^ Rcon[i/Nk]
    - Nk=8 and i mod Nk = 4: SubWord(w[i-1])
    - otherwise: w[i-1]
  - For i≥Nk the window shifts the new word in and drops the oldest.
  - Words accumulate in a 3-word collector.
  - On the push of the 4th word of a group (i mod 4 = 3), collector + new word load rk, rk_valid=1, rk_index=i/4, and the collector clears.
  - Stall: if i mod 4 = 3 and rk_valid=1 and rk_ready=0, the push does not occur; i, window and collector hold.
  - Simultaneous accept and load in one cycle is allowed, giving back-to-back keys.
  - When i = 4*(Nr+1)-1 is pushed, go to DRAIN.
- DRAIN: wait for acceptance of the last key (rk_index=Nr). On that edge: rk_valid=0, busy=0, done=1 for one cycle, return to IDLE.
- Outside of loading, rk_valid clears on any edge where rk_valid=1 and rk_ready=1. rk holds its value after clearing.
- Latency with rk_ready tied high:
  - start edge T0; rk_valid rises after edge T4 with rk_index 0.
  - Key k becomes valid after edge T4+4k.
  - Total expansion is 4*(Nr+1) push cycles: 44/52/60 for Nk=4/6/8.
- Rcon index range: 1..10 for Nk=4; lower maxima for Nk=6/8. Values come from the package table.

Decomposition:
- Package aes_pkg:
  - S-box table (256x8)
  - Rcon table (1..10)
  - function nr_of(Nk)
  - round-key width constant 128
- Sub-module key_sub_word: combinational SubWord of 32 bits, four S-box lookups from the package table. Reusable by SubBytes.
- The key_schedule top holds the FSM, counter, window, collector and output register.

Test Plan:
- AES-128 (FIPS-197 A.1), key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - rk0 = key; rk1 = a0fafe1788542cb123a339392a6c7605; rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Keys valid after T4, T8, …, T44; done pulses after the T44 acceptance.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - rk1 = 62f8ead2522c6b7bfe0c91f72402f5a5; 13 keys total, rk_index 0..12.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - rk1 = 1f352c073b6108d72d9810a30914dff4; rk2 = 9ba354118e6925afa51a8b5f2067fcde (checks the i mod 8 = 4 SubWord path); 15 keys total.
- Backpressure:
  - Hold rk_ready=0 for 7 cycles at rk_index 1, and toggle rk_ready randomly elsewhere.
  - rk and rk_index stay stable while stalled; no key is skipped or duplicated; the final values match the unstalled run.
- start asserted while busy and during DRAIN:
  - No restart; the key sequence is unchanged.
  - A start one cycle after done begins a new expansion from rk_index 0.
- rst_n pulsed low at rk_index 5:
  - rk_valid, busy and done go 0 immediately (asynchronously).
  - A subsequent start produces the full correct sequence from rk0.
